dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, meaning the number of 32-bit storage words (power of two, 4..1024).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, meaning the wait states inserted between request acceptance and response (0..15).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning the asynchronous, active-low reset.
REQ-005 SHALL have port req  input  1  meaning the initiator has a valid access on the request inputs.
REQ-006 SHALL have port ready  output  1  meaning the responder can accept a request this cycle.
REQ-007 SHALL have port memwrite  input  1  meaning 1 = store, 0 = load.
REQ-008 SHALL have port readWriteType  input  1  meaning 1 = byte access, 0 = word access.
REQ-009 SHALL have port chooseExtend  input  1  meaning 1 = sign-extend byte loads, 0 = zero-extend.
REQ-010 SHALL have port addr  input  32  meaning the byte address.
REQ-011 SHALL have port writedata  input  32  meaning the store data; byte stores use bits [7:0].
REQ-012 SHALL have port rvalid  output  1  meaning a one-cycle response strobe for loads and stores.
REQ-013 SHALL have port readdata  output  32  meaning the load result, valid while rvalid=1.
REQ-014 SHALL have port err  output  1  meaning a misaligned-access error, qualified by rvalid.

Function
REQ-015 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-016 SHALL drive ready=1 only in IDLE; a request is accepted on a rising edge where req&ready=1.
REQ-017 SHALL register memwrite, readWriteType, chooseExtend, addr and writedata on acceptance; request inputs are ignored afterwards until the next IDLE.
REQ-018 On acceptance, SHALL go IDLE->WAIT and load the wait counter with WAIT_CYCLES-1 when WAIT_CYCLES>0, or go IDLE->RESP when WAIT_CYCLES=0.
REQ-019 SHALL decrement the counter each cycle in WAIT and go WAIT->RESP when the counter is 0.
REQ-020 In RESP, SHALL hold rvalid=1 for exactly one cycle, then return to IDLE; back-to-back requests therefore have a spacing of WAIT_CYCLES+2 cycles.
REQ-021 SHALL give rvalid a latency of exactly WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-022 SHALL commit stores on the edge that enters RESP; a load and store to the same word in consecutive transactions SHALL see the new data.
REQ-023 SHALL form the word index from addr[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-024 SHALL use big-endian byte lanes: addr[1:0]=0 maps to bits [31:24] and addr[1:0]=3 maps to bits [7:0].
REQ-025 A byte store SHALL update only the addressed lane, using writedata[7:0].
REQ-026 A byte load SHALL return the addressed lane, sign-extended when chooseExtend=1 and zero-extended otherwise.
REQ-027 A word load SHALL return the full word and ignore chooseExtend.
REQ-028 SHALL drive readdata with the loaded value in RESP for loads, and 0 in RESP for stores; readdata SHALL hold its last value outside RESP.

Reset
REQ-029 reset=0 SHALL asynchronously force state IDLE, counter 0, rvalid=0, err=0 and readdata=0; ready=1 follows from IDLE.
REQ-030 Reset asserted in WAIT SHALL abort the transaction, and a pending store SHALL NOT be committed.
REQ-031 Reset SHALL NOT clear the storage array; its contents are undefined after power-up.

Configuration
REQ-032 With macro DMEM_MISALIGN_ERR_EN defined, a word access with addr[1:0]!=0 SHALL produce rvalid with err=1; a store SHALL be suppressed and a load SHALL return readdata=0.
REQ-033 Without DMEM_MISALIGN_ERR_EN, err SHALL be tied to 0 and word accesses SHALL ignore addr[1:0].

Verification
REQ-034 WAIT_CYCLES=1: word store addr=0x10, data=0xDEADBEEF, then word load addr=0x10 -> rvalid 2 cycles after each acceptance, readdata=0xDEADBEEF.
REQ-035 Preload 0x12345680 at addr 0x20; byte load addr=0x23 with chooseExtend=1 -> 0xFFFFFF80; with chooseExtend=0 -> 0x00000080.
REQ-036 Byte store 0xAA at addr=0x21 over 0x11223344 -> word load at 0x20 returns 0x11AA3344.
REQ-037 DEPTH_WORDS=64: store at addr 0x104, load at 0x004 -> same data (wrap); with req held high, ready is low for WAIT_CYCLES+1 cycles after each acceptance.
REQ-038 Reset pulsed low during WAIT of a store to 0x30 -> FSM in IDLE and rvalid=0 at once; a later load from 0x30 returns the prior contents.
REQ-039 DMEM_MISALIGN_ERR_EN defined: word store at addr=0x41 -> err=1 with rvalid, and word 0x40 is unchanged.

Source files
------------

// File: rtl/dmem_responder.sv
// Single-port data memory responder: IDLE/WAIT/RESP handshake with configurable wait states.
// Define DMEM_MISALIGN_ERR_EN to flag misaligned word accesses through err.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 64,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   output logic        ready,
   input  logic        memwrite,
   input  logic        readWriteType,
   input  logic        chooseExtend,
   input  logic [31:0] addr,
   input  logic [31:0] writedata,
   output logic        rvalid,
   output logic [31:0] readdata,
   output logic        err
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam bit NoWait = (WAIT_CYCLES == 0);
   localparam logic [3:0] WaitLoad = NoWait ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e        r_state;
   logic [3:0]    r_cnt;
   logic          r_memwrite;
   logic          r_byte;
   logic          r_sext;
   logic [AW+1:0] r_addr;
   logic [31:0]   r_wdata;
   logic          r_rvalid;
   logic [31:0]   r_readdata;
   logic          r_err;
   logic [31:0]   r_mem [DEPTH_WORDS];

   logic          w_idle;
   logic          w_enter_resp;
   logic          w_op_mw;
   logic          w_op_byte;
   logic          w_op_sext;
   logic [AW+1:0] w_op_addr;
   logic [31:0]   w_op_wdata;
   logic [AW-1:0] w_idx;
   logic [1:0]    w_lane;
   logic [31:0]   w_word;
   logic [7:0]    w_byte;
   logic [31:0]   w_merged;
   logic [31:0]   w_store_word;
   logic [31:0]   w_load;
   logic [31:0]   w_rdata_next;
   logic          w_misalign;
   logic          w_we;
   logic          w_unused_addr;

   assign w_unused_addr = ^addr[31:AW+2];

   assign w_idle       = (r_state == StIdle);
   assign w_enter_resp = (NoWait && w_idle && req) || (r_state == StWait && r_cnt == 4'd0);

   // With no wait states RESP is entered on the acceptance edge, so use the live inputs there.
   assign w_op_mw    = w_idle ? memwrite         : r_memwrite;
   assign w_op_byte  = w_idle ? readWriteType    : r_byte;
   assign w_op_sext  = w_idle ? chooseExtend     : r_sext;
   assign w_op_addr  = w_idle ? addr[AW+1:0]     : r_addr;
   assign w_op_wdata = w_idle ? writedata        : r_wdata;

   assign w_idx  = w_op_addr[AW+1:2];
   assign w_lane = w_op_addr[1:0];
   assign w_word = r_mem[w_idx];

   // Big-endian lanes: lane 0 is the most significant byte.
   always_comb begin
      w_byte   = w_word[7:0];
      w_merged = w_word;
      unique case (w_lane)
         2'd0: begin
            w_byte          = w_word[31:24];
            w_merged[31:24] = w_op_wdata[7:0];
         end
         2'd1: begin
            w_byte          = w_word[23:16];
            w_merged[23:16] = w_op_wdata[7:0];
         end
         2'd2: begin
            w_byte          = w_word[15:8];
            w_merged[15:8]  = w_op_wdata[7:0];
         end
         default: begin
            w_byte          = w_word[7:0];
            w_merged[7:0]   = w_op_wdata[7:0];
         end
      endcase
   end

`ifdef DMEM_MISALIGN_ERR_EN
   assign w_misalign = ~w_op_byte & (w_lane != 2'd0);
`else
   assign w_misalign = 1'b0;
`endif

   assign w_store_word = w_op_byte ? w_merged : w_op_wdata;
   assign w_load       = w_op_byte ? {{24{w_op_sext & w_byte[7]}}, w_byte} : w_word;
   assign w_rdata_next = (w_op_mw | w_misalign) ? 32'd0 : w_load;
   assign w_we         = reset & w_enter_resp & w_op_mw & ~w_misalign;

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[w_idx] <= w_store_word;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= StIdle;
         r_cnt      <= 4'd0;
         r_memwrite <= 1'b0;
         r_byte     <= 1'b0;
         r_sext     <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= 32'd0;
         r_rvalid   <= 1'b0;
         r_readdata <= 32'd0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               if (req) begin
                  r_memwrite <= memwrite;
                  r_byte     <= readWriteType;
                  r_sext     <= chooseExtend;
                  r_addr     <= addr[AW+1:0];
                  r_wdata    <= writedata;
                  if (NoWait) begin
                     r_state    <= StResp;
                     r_rvalid   <= 1'b1;
                     r_readdata <= w_rdata_next;
                     r_err      <= w_misalign;
                  end else begin
                     r_state <= StWait;
                     r_cnt   <= WaitLoad;
                  end
               end
            end
            StWait: begin
               if (r_cnt == 4'd0) begin
                  r_state    <= StResp;
                  r_rvalid   <= 1'b1;
                  r_readdata <= w_rdata_next;
                  r_err      <= w_misalign;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            StResp: begin
               r_state  <= StIdle;
               r_rvalid <= 1'b0;
               r_err    <= 1'b0;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign ready    = w_idle;
   assign rvalid   = r_rvalid;
   assign readdata = r_readdata;
   assign err      = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder plus hand-written reset/handshake sequences.
module tb_dmem_responder;

   localparam int unsigned W     = 1;
   localparam int unsigned DEPTH = 64;
`ifdef DMEM_MISALIGN_ERR_EN
   localparam bit ErrEn = 1'b1;
`else
   localparam bit ErrEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic        ready;
   logic        memwrite;
   logic        readWriteType;
   logic        chooseExtend;
   logic [31:0] addr;
   logic [31:0] writedata;
   logic        rvalid;
   logic [31:0] readdata;
   logic        err;

   dmem_responder #(
      .DEPTH_WORDS(DEPTH),
      .WAIT_CYCLES(W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .ready        (ready),
      .memwrite     (memwrite),
      .readWriteType(readWriteType),
      .chooseExtend (chooseExtend),
      .addr         (addr),
      .writedata    (writedata),
      .rvalid       (rvalid),
      .readdata     (readdata),
      .err          (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        mw;
      logic        bt;
      logic        se;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] exp;
      logic        exp_err;
   } vec_t;

   vec_t vq[$];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
   endtask

   task automatic add(input logic mw, input logic bt, input logic se, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp, input logic e);
      vq.push_back('{mw, bt, se, a, wd, exp, e});
   endtask

   // Issue one request, then scramble the request inputs to prove they are ignored.
   task automatic access(input logic mw, input logic bt, input logic se, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic e,
                         output int lat);
      int k;
      lat = 0;
      rd  = 32'd0;
      e   = 1'b0;
      k   = 0;
      @(negedge clk);
      while (!ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      req           = 1'b1;
      memwrite      = mw;
      readWriteType = bt;
      chooseExtend  = se;
      addr          = a;
      writedata     = wd;
      @(posedge clk);
      #1;
      req           = 1'b0;
      memwrite      = 1'($urandom);
      readWriteType = 1'($urandom);
      chooseExtend  = 1'($urandom);
      addr          = $urandom;
      writedata     = $urandom;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (rvalid) begin
            lat = i;
            rd  = readdata;
            e   = err;
            break;
         end
      end
      @(negedge clk);
      check("rvalid_one_cycle", {31'd0, rvalid}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] rd;
      logic        e;
      int          lat;

      add(1, 0, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0);
      add(0, 0, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0);
      add(1, 0, 0, 32'h20,  32'h12345680, 32'h0,        0);
      add(0, 1, 1, 32'h23,  32'h0,        32'hFFFFFF80, 0);
      add(0, 1, 0, 32'h23,  32'h0,        32'h00000080, 0);
      add(0, 1, 1, 32'h20,  32'h0,        32'h00000012, 0);
      add(1, 0, 0, 32'h20,  32'h11223344, 32'h0,        0);
      add(1, 1, 0, 32'h21,  32'h123456AA, 32'h0,        0);
      add(0, 0, 1, 32'h20,  32'h0,        32'h11AA3344, 0);
      add(0, 1, 1, 32'h21,  32'h0,        32'hFFFFFFAA, 0);
      add(1, 0, 0, 32'h104, 32'hCAFEF00D, 32'h0,        0);
      add(0, 0, 0, 32'h004, 32'h0,        32'hCAFEF00D, 0);
      add(0, 1, 0, 32'h107, 32'h0,        32'h0000000D, 0);
      add(1, 1, 0, 32'h13,  32'h00000055, 32'h0,        0);
      add(0, 0, 0, 32'h10,  32'h0,        32'hDEADBE55, 0);
      add(1, 0, 0, 32'h30,  32'h0BADF00D, 32'h0,        0);
      add(1, 0, 0, 32'h40,  32'h01020304, 32'h0,        0);
      add(1, 0, 0, 32'h41,  32'hFFFFFFFF, 32'h0,        ErrEn);
      add(0, 0, 0, 32'h40,  32'h0,        ErrEn ? 32'h01020304 : 32'hFFFFFFFF, 0);
      add(0, 0, 0, 32'h42,  32'h0,        ErrEn ? 32'h0 : 32'hFFFFFFFF, ErrEn);
      add(0, 1, 0, 32'h41,  32'h0,        ErrEn ? 32'h02 : 32'hFF, 0);

      reset         = 1'b0;
      req           = 1'b0;
      memwrite      = 1'b0;
      readWriteType = 1'b0;
      chooseExtend  = 1'b0;
      addr          = 32'd0;
      writedata     = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ready",    {31'd0, ready},  32'd1);
      check("reset_rvalid",   {31'd0, rvalid}, 32'd0);
      check("reset_err",      {31'd0, err},    32'd0);
      check("reset_readdata", readdata,        32'd0);
      @(negedge clk);
      reset = 1'b1;

      foreach (vq[i]) begin
         access(vq[i].mw, vq[i].bt, vq[i].se, vq[i].a, vq[i].wd, rd, e, lat);
         check($sformatf("v%0d_readdata", i), rd, vq[i].exp);
         check($sformatf("v%0d_err", i), {31'd0, e}, {31'd0, vq[i].exp_err});
         check($sformatf("v%0d_latency", i), 32'(lat), 32'(W + 1));
      end

      // readdata holds the last load result while idle.
      repeat (3) @(negedge clk);
      check("hold_readdata", readdata, vq[vq.size() - 1].exp);
      check("hold_rvalid", {31'd0, rvalid}, 32'd0);

      // req held high: ready is low for W+1 cycles after each acceptance.
      @(negedge clk);
      req           = 1'b1;
      memwrite      = 1'b0;
      readWriteType = 1'b0;
      addr          = 32'h10;
      for (int i = 0; i < 3 * (W + 2); i++) begin
         check($sformatf("backtoback_ready_%0d", i), {31'd0, ready},
               {31'd0, (i % (W + 2)) == 0});
         @(negedge clk);
      end
      req = 1'b0;
      repeat (W + 3) @(negedge clk);

      // Reset during WAIT of a store aborts it and clears outputs immediately.
      check("pre_abort_readdata", readdata, 32'hDEADBE55);
      req           = 1'b1;
      memwrite      = 1'b1;
      readWriteType = 1'b0;
      addr          = 32'h30;
      writedata     = 32'hFFFFFFFF;
      @(posedge clk);
      #1;
      req = 1'b0;
      check("abort_in_wait_ready", {31'd0, ready}, 32'd0);
      #2;
      reset = 1'b0;
      #1;
      check("abort_ready",    {31'd0, ready},  32'd1);
      check("abort_rvalid",   {31'd0, rvalid}, 32'd0);
      check("abort_readdata", readdata,        32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("abort_no_rvalid", {31'd0, rvalid}, 32'd0);
      reset = 1'b1;
      access(1'b0, 1'b0, 1'b0, 32'h30, 32'h0, rd, e, lat);
      check("abort_store_dropped", rd, 32'h0BADF00D);
      check("abort_load_latency", 32'(lat), 32'(W + 1));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
